// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared types for the cache <-> memory request channel.
//   DATA_FIELD_WIDTH / ADDR_FIELD_WIDTH : payload and address widths
//   access_type_t                       : READ_REQ, READ_RSP, WRITE_REQ, WRITE_RSP
//   request_t                           : one request or response beat
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  localparam int DATA_FIELD_WIDTH = 64;
  localparam int ADDR_FIELD_WIDTH = 32;
  localparam int ID_FIELD_WIDTH   = 8;
  localparam int CORE_FIELD_WIDTH = 4;
  localparam int LEN_FIELD_WIDTH  = 4;
  localparam int BYTE_EN_WIDTH    = DATA_FIELD_WIDTH / 8;

  typedef enum logic [1:0] {
    READ_REQ  = 2'd0,
    READ_RSP  = 2'd1,
    WRITE_REQ = 2'd2,
    WRITE_RSP = 2'd3
  } access_type_t;

  typedef struct packed {
    logic                        vld;
    access_type_t                access_type;
    logic [ID_FIELD_WIDTH-1:0]   access_id;
    logic [CORE_FIELD_WIDTH-1:0] core_id;
    logic [ADDR_FIELD_WIDTH-1:0] addr;
    logic [LEN_FIELD_WIDTH-1:0]  access_length;
    logic [BYTE_EN_WIDTH-1:0]    byte_en;
    logic [DATA_FIELD_WIDTH-1:0] data;
  } request_t;

  // True for the two request kinds the responder actually services.
  function automatic logic is_mem_op(input access_type_t t);
    return (t == READ_REQ) || (t == WRITE_REQ);
  endfunction

endpackage

// File: rtl/mem_responder_req_fifo.sv
// -----------------------------------------------------------------------------
// req_fifo
// Small circular request buffer with a combinational head view.
//   clk, reset (async, active-high)
//   push / push_data : enqueue at tail (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   head_data        : current head entry
//   full / empty     : occupancy flags, derived from registered state only
// -----------------------------------------------------------------------------
module req_fifo
  import mem_responder_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = request_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head_data,
  output logic full,
  output logic empty
);

  localparam int           AW        = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_CNT = (AW + 1)'(DEPTH);

  T              entry_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = entry_mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Fixed-latency memory model answering cache requests from a 64-bit word store.
//   clk       : single clock, posedge
//   reset     : asynchronous active-high reset (memory contents are kept)
//   mem_req   : request from the cache, accepted when vld && req_grant
//   req_grant : high whenever the request buffer has room
//   mem_rsp   : one-cycle response beat, all-zero when idle, no backpressure
//   addr_err  : pulses with a response whose address is out of range
// Optional feature macro: MEM_RESPONDER_ADDR_CHECK_EN
//   defined   -> addr >= MEM_DEPTH reads 0 / drops the write and flags addr_err
//   undefined -> address wraps modulo MEM_DEPTH, addr_err is constant 0
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  request_t mem_req,
  output logic     req_grant,
  output request_t mem_rsp,
  output logic     addr_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_push;
  logic                        fifo_pop;
  request_t                    fifo_head;

  logic [0:0]                  state_reg;
  logic [LAT_W-1:0]            lat_cnt_reg;
  request_t                    cur_req_reg;
  request_t                    mem_rsp_reg;
  request_t                    rsp_next;

  logic                        rsp_fire;
  logic                        is_read;
  logic                        is_write;
  logic                        addr_oob;
  logic                        wr_en;
  logic [IDX_W-1:0]            rd_idx;
  logic [IDX_W-1:0]            wr_idx;
  logic [DATA_FIELD_WIDTH-1:0] rd_data;

  // Grant comes only from registered occupancy, never from mem_req.
  assign req_grant = !fifo_full;
  assign fifo_push = mem_req.vld && !fifo_full;
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (request_t)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mem_req),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_fire = (state_reg == WAIT) && (lat_cnt_reg == '0);
  assign is_read  = cur_req_reg.vld && (cur_req_reg.access_type == READ_REQ);
  assign is_write = cur_req_reg.vld && (cur_req_reg.access_type == WRITE_REQ);
  assign rd_idx   = fifo_head.addr[IDX_W-1:0];
  assign wr_idx   = cur_req_reg.addr[IDX_W-1:0];
  assign wr_en    = rsp_fire && is_write && !addr_oob;

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  logic addr_err_reg;

  assign addr_oob = (cur_req_reg.addr >= ADDR_FIELD_WIDTH'(MEM_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= rsp_fire && is_mem_op(cur_req_reg.access_type) && cur_req_reg.vld && addr_oob;
    end
  end

  assign addr_err = addr_err_reg;
`else
  assign addr_oob = 1'b0;
  assign addr_err = 1'b0;
`endif

  // Backing store split into byte lanes so byte enables map onto
  // independent RAM write ports. The read is taken on the pop edge: every
  // earlier request has already completed its write by then, so the
  // registered lane data is exactly what this request must return.
  genvar gi;
  generate
    for (gi = 0; gi < BYTE_EN_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (wr_en && cur_req_reg.byte_en[gi]) begin
          lane_mem[wr_idx] <= cur_req_reg.data[gi*8 +: 8];
        end
        if (fifo_pop) begin
          rd_lane_reg <= lane_mem[rd_idx];
        end
      end

      assign rd_data[gi*8 +: 8] = rd_lane_reg;
    end
  endgenerate

  // Response beat for the request in service; unsupported types yield zero.
  always_comb begin
    rsp_next = '0;
    if (is_read) begin
      rsp_next.vld           = 1'b1;
      rsp_next.access_type   = READ_RSP;
      rsp_next.access_id     = cur_req_reg.access_id;
      rsp_next.core_id       = cur_req_reg.core_id;
      rsp_next.addr          = cur_req_reg.addr;
      rsp_next.access_length = cur_req_reg.access_length;
      rsp_next.byte_en       = '0;
      rsp_next.data          = addr_oob ? '0 : rd_data;
    end else if (is_write) begin
      rsp_next.vld           = 1'b1;
      rsp_next.access_type   = WRITE_RSP;
      rsp_next.access_id     = cur_req_reg.access_id;
      rsp_next.core_id       = cur_req_reg.core_id;
      rsp_next.addr          = cur_req_reg.addr;
      rsp_next.access_length = cur_req_reg.access_length;
      rsp_next.byte_en       = cur_req_reg.byte_en;
      rsp_next.data          = '0;
    end
  end

  // IDLE pops and loads the latency counter; WAIT counts down and emits
  // the response on the edge where the counter is already zero, giving a
  // RD_LATENCY+1 cycle turnaround per request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      cur_req_reg <= '0;
      mem_rsp_reg <= '0;
    end else begin
      mem_rsp_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            cur_req_reg <= fifo_head;
            lat_cnt_reg <= LAT_W'(RD_LATENCY - 1);
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_reg == '0) begin
            mem_rsp_reg <= rsp_next;
            state_reg   <= IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_rsp = mem_rsp_reg;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed and randomized checks of mem_responder against a behavioural model
// (word array + ordered queue of expected responses).
// -----------------------------------------------------------------------------
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int MEM_DEPTH  = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LATENCY = 2;

  logic     clk = 1'b0;
  logic     reset;
  request_t mem_req;
  logic     req_grant;
  request_t mem_rsp;
  logic     addr_err;

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_DEPTH  (MEM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .req_grant (req_grant),
    .mem_rsp   (mem_rsp),
    .addr_err  (addr_err)
  );

  typedef struct {
    request_t rsp;
    logic     err;
    int       cyc;
  } obs_t;

  typedef struct {
    request_t rsp;
    logic     err;
    bit       data_known;
    int       acc;
  } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   idle_bad = 0;
  obs_t obs_q[$];
  exp_t exp_q[$];

  logic [63:0] model_mem   [MEM_DEPTH];
  bit          model_known [MEM_DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: records every valid beat, counts non-zero idle cycles.
  always @(negedge clk) begin
    obs_t o;
    if (mem_rsp.vld === 1'b1) begin
      o.rsp = mem_rsp;
      o.err = addr_err;
      o.cyc = cyc;
      obs_q.push_back(o);
    end else if (mem_rsp !== '0 || addr_err !== 1'b0) begin
      idle_bad <= idle_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic request_t mk(input access_type_t t, input int id,
                                  input logic [31:0] addr, input logic [63:0] data,
                                  input logic [7:0] be);
    request_t r;
    r               = '0;
    r.vld           = 1'b1;
    r.access_type   = t;
    r.access_id     = 8'(id);
    r.core_id       = 4'($urandom);
    r.addr          = addr;
    r.access_length = 4'($urandom);
    r.byte_en       = be;
    r.data          = data;
    return r;
  endfunction

  // Behavioural model: requests take effect in acceptance order.
  task automatic model_accept(input request_t r, input int acc);
    int   idx = int'(r.addr % 32'(MEM_DEPTH));
    bit   oob = 1'b0;
    exp_t e;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    oob = (r.addr >= 32'(MEM_DEPTH));
`endif
    e.rsp        = '0;
    e.err        = oob;
    e.data_known = 1'b1;
    e.acc        = acc;
    if (r.access_type == READ_REQ || r.access_type == WRITE_REQ) begin
      e.rsp.vld           = 1'b1;
      e.rsp.access_id     = r.access_id;
      e.rsp.core_id       = r.core_id;
      e.rsp.addr          = r.addr;
      e.rsp.access_length = r.access_length;
      if (r.access_type == READ_REQ) begin
        e.rsp.access_type = READ_RSP;
        e.rsp.byte_en     = '0;
        if (!oob) begin
          e.rsp.data   = model_mem[idx];
          e.data_known = model_known[idx];
        end
      end else begin
        e.rsp.access_type = WRITE_RSP;
        e.rsp.byte_en     = r.byte_en;
        if (!oob) begin
          if (r.byte_en == 8'hFF) model_known[idx] = 1'b1;
          for (int k = 0; k < 8; k++)
            if (r.byte_en[k]) model_mem[idx][k*8 +: 8] = r.data[k*8 +: 8];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input request_t r);
    int waited = 0;
    mem_req = r;
    while (req_grant !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      chk("grant_timeout", {63'd0, req_grant}, 64'd1);
      mem_req = '0;
    end else begin
      model_accept(r, cyc + 1);
      @(negedge clk);
      mem_req = '0;
    end
  endtask

  task automatic drain(input string tag, input bit chk_spacing, input bit chk_latency);
    int   budget = 40 + exp_q.size() * (RD_LATENCY + 1) * 2;
    int   prev = -1;
    obs_t o;
    exp_t e;
    while (obs_q.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      $display("TXN %s id=%0d type=%0d addr=%0d data=%h err=%0b cyc=%0d",
               tag, o.rsp.access_id, o.rsp.access_type, o.rsp.addr, o.rsp.data, o.err, o.cyc);
      chk({tag, "_type"}, 64'(o.rsp.access_type), 64'(e.rsp.access_type));
      chk({tag, "_id"}, 64'(o.rsp.access_id), 64'(e.rsp.access_id));
      chk({tag, "_echo"}, {o.rsp.core_id, o.rsp.access_length, o.rsp.byte_en, o.rsp.addr},
          {e.rsp.core_id, e.rsp.access_length, e.rsp.byte_en, e.rsp.addr});
      if (e.data_known) chk({tag, "_data"}, o.rsp.data, e.rsp.data);
      chk({tag, "_err"}, 64'(o.err), 64'(e.err));
      if (chk_latency) chk({tag, "_latency"}, 64'(o.cyc - e.acc), 64'(RD_LATENCY + 1));
      if (chk_spacing && prev >= 0) chk({tag, "_spacing"}, 64'(o.cyc - prev), 64'(RD_LATENCY + 1));
      prev = o.cyc;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          n_obs;
    bit          seen_stall;
    logic [63:0] d;
    access_type_t t;
    logic [31:0] a;

    // Reset state
    reset   = 1'b1;
    mem_req = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp", mem_rsp, 64'd0);
    chk("reset_addr_err", {63'd0, addr_err}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_grant", {63'd0, req_grant}, 64'd1);

    // Single read with fixed latency
    send(mk(WRITE_REQ, 1, 32'd5, 64'h0000_0000_0000_00A5, 8'hFF));
    drain("pre5", 1'b0, 1'b1);
    send(mk(READ_REQ, 64, 32'd5, 64'd0, 8'h00));
    drain("rd5", 1'b0, 1'b1);

    // Partial write then read of the same word
    send(mk(WRITE_REQ, 2, 32'd7, 64'd0, 8'hFF));
    send(mk(WRITE_REQ, 3, 32'd7, 64'h1122_3344_5566_7788, 8'h0F));
    send(mk(READ_REQ, 4, 32'd7, 64'd0, 8'h00));
    drain("bytewr", 1'b0, 1'b0);

    // Preload words 0..31, then a held burst of 32 reads
    for (int i = 0; i < 32; i++) send(mk(WRITE_REQ, i, 32'(i), {$urandom, $urandom}, 8'hFF));
    drain("preload", 1'b1, 1'b0);
    seen_stall = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!seen_stall && req_grant === 1'b0) begin
        seen_stall = 1'b1;
        chk("burst_backlog", 64'(i - obs_q.size()), 64'(FIFO_DEPTH + 1));
      end
      send(mk(READ_REQ, 64 + i, 32'(i), 64'd0, 8'h00));
    end
    chk("burst_stall_seen", {63'd0, seen_stall}, 64'd1);
    drain("burst", 1'b1, 1'b0);

    // Randomized mix, including ignored types and out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8:   t = READ_REQ;
        9, 10, 11, 12, 13, 14, 15, 16: t = WRITE_REQ;
        17:                          t = READ_RSP;
        default:                     t = WRITE_RSP;
      endcase
      a = ($urandom_range(0, 9) == 0) ? 32'(MEM_DEPTH + $urandom_range(0, 3))
                                      : 32'($urandom_range(0, 15));
      send(mk(t, $urandom_range(0, 255), a, {$urandom, $urandom}, 8'($urandom)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand", 1'b0, 1'b0);

    // Reset while busy: 1 in service, 3 buffered
    d = 64'hDEAD_BEEF_CAFE_F00D;
    send(mk(WRITE_REQ, 9, 32'd9, d, 8'hFF));
    drain("prerst", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(mk(READ_REQ, 200 + i, 32'd9, 64'd0, 8'h00));
    n_obs = obs_q.size();
    chk("rst_pre_count", 64'(n_obs), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_rsp_zero", mem_rsp, 64'd0);
    chk("rst_grant", {63'd0, req_grant}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_silent", 64'(obs_q.size()), 64'(n_obs));
    chk("rst_grant_after", {63'd0, req_grant}, 64'd1);
    while (exp_q.size() > n_obs) void'(exp_q.pop_back());
    drain("rst", 1'b0, 1'b0);
    send(mk(READ_REQ, 99, 32'd9, 64'd0, 8'h00));
    drain("retain", 1'b0, 1'b1);

    // Out-of-range addressing
    send(mk(WRITE_REQ, 10, 32'd0, 64'h0123_4567_89AB_CDEF, 8'hFF));
    send(mk(WRITE_REQ, 11, 32'd1, 64'h0000_0000_0000_1111, 8'hFF));
    send(mk(READ_REQ, 77, 32'(MEM_DEPTH), 64'd0, 8'h00));
    send(mk(WRITE_REQ, 12, 32'(MEM_DEPTH + 1), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF));
    send(mk(READ_REQ, 78, 32'd1, 64'd0, 8'h00));
    drain("oob", 1'b1, 1'b0);

    chk("idle_rsp_zero", 64'(idle_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
